wb_arbiter: RTL and testbench

Writeback stage sitting directly upstream of the integer register file: arbitrates result traffic from the execute unit (EXU) and the load/store unit (LSU), registers the single winning write onto the register file write port, and maintains a pending-write scoreboard that the decode stage queries for RAW/WAW hazards. It guarantees at most one register file write per cycle. A scoreboard bit stays set until the cycle in which the register file actually commits the write.

---
 rtl/wb_arbiter_if.sv | 50 +++++
 rtl/wb_arbiter.sv | 87 ++++++++
 tb/tb_wb_arbiter.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// Writeback bus bundle: EXU/LSU result sources, decode issue and hazard query,
// and the register file write port.
interface wb_arbiter_if #(
    parameter int XLEN = 64,
    parameter int RA_W = 5
);
    logic            ex_valid;
    logic            ex_ready;
    logic            ex_wen;
    logic [RA_W-1:0] ex_rd;
    logic [XLEN-1:0] ex_data;

    logic            ls_valid;
    logic            ls_ready;
    logic            ls_wen;
    logic [RA_W-1:0] ls_rd;
    logic [XLEN-1:0] ls_data;

    logic            iss_valid;
    logic            iss_wen;
    logic [RA_W-1:0] iss_rd;
    logic            iss_ready;

    logic [RA_W-1:0] rs1_addr;
    logic [RA_W-1:0] rs2_addr;
    logic            rs1_busy;
    logic            rs2_busy;

    logic            flush;

    logic            wr_en_o;
    logic [RA_W-1:0] wr_addr_o;
    logic [XLEN-1:0] wr_data_o;

    modport master (
        output ex_valid, ex_wen, ex_rd, ex_data,
        output ls_valid, ls_wen, ls_rd, ls_data,
        output iss_valid, iss_wen, iss_rd, rs1_addr, rs2_addr, flush,
        input  ex_ready, ls_ready, iss_ready, rs1_busy, rs2_busy,
        input  wr_en_o, wr_addr_o, wr_data_o
    );

    modport slave (
        input  ex_valid, ex_wen, ex_rd, ex_data,
        input  ls_valid, ls_wen, ls_rd, ls_data,
        input  iss_valid, iss_wen, iss_rd, rs1_addr, rs2_addr, flush,
        output ex_ready, ls_ready, iss_ready, rs1_busy, rs2_busy,
        output wr_en_o, wr_addr_o, wr_data_o
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin EXU/LSU merge onto the single register file
// write port, plus the pending-write scoreboard queried by decode.
module wb_arbiter #(
    parameter int XLEN = 64,
    parameter int RA_W = 5
) (
    input logic        clk,
    input logic        rst,
    wb_arbiter_if.slave bus
);
    localparam int NREG = 1 << RA_W;

    typedef enum logic {
        GNT_EXU = 1'b0,
        GNT_LSU = 1'b1
    } grant_t;

    grant_t          last_grant;
    logic            both_vld;
    logic            pick_ls;
    logic            xfer;
    logic            win_wen;
    logic [RA_W-1:0] win_rd;
    logic [XLEN-1:0] win_data;
    logic            iss_fire;

    logic            wr_en_p1;
    logic [RA_W-1:0] wr_addr_p1;
    logic [XLEN-1:0] wr_data_p1;

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_set;
    logic [NREG-1:0] busy_clr;
    logic [NREG-1:0] busy_nxt;

    // Arbitration: LSU wins alone, or on a conflict when EXU won the last one.
    always_comb begin
        both_vld = bus.ex_valid && bus.ls_valid;
        pick_ls  = bus.ls_valid && (!bus.ex_valid || last_grant == GNT_EXU);
        xfer     = bus.ex_valid || bus.ls_valid;
        win_wen  = pick_ls ? bus.ls_wen  : bus.ex_wen;
        win_rd   = pick_ls ? bus.ls_rd   : bus.ex_rd;
        win_data = pick_ls ? bus.ls_data : bus.ex_data;
    end

    assign bus.ex_ready = bus.ex_valid && !pick_ls;
    assign bus.ls_ready = pick_ls;

    assign bus.iss_ready = !(bus.iss_wen && bus.iss_rd != '0 && busy[bus.iss_rd]);
    assign iss_fire      = bus.iss_valid && bus.iss_ready && bus.iss_wen && bus.iss_rd != '0;

    assign bus.rs1_busy = (bus.rs1_addr != '0) && busy[bus.rs1_addr];
    assign bus.rs2_busy = (bus.rs2_addr != '0) && busy[bus.rs2_addr];

    // Set beats clear on the same index; flush beats both; x0 never pends.
    always_comb begin
        busy_set = '0;
        busy_clr = '0;
        if (iss_fire) busy_set[bus.iss_rd] = 1'b1;
        if (wr_en_p1) busy_clr[wr_addr_p1] = 1'b1;
        busy_nxt    = bus.flush ? '0 : ((busy & ~busy_clr) | busy_set);
        busy_nxt[0] = 1'b0;
    end

    // Stage p1: registered register file write port and scoreboard state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_p1   <= 1'b0;
            wr_addr_p1 <= '0;
            wr_data_p1 <= '0;
            busy       <= '0;
            last_grant <= GNT_EXU;
        end else begin
            wr_en_p1 <= xfer && win_wen && win_rd != '0;
            if (xfer) begin
                wr_addr_p1 <= win_rd;
                wr_data_p1 <= win_data;
            end
            if (both_vld) last_grant <= pick_ls ? GNT_LSU : GNT_EXU;
            busy <= busy_nxt;
        end
    end

    assign bus.wr_en_o   = wr_en_p1;
    assign bus.wr_addr_o = wr_addr_p1;
    assign bus.wr_data_o = wr_data_p1;
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus constrained-random traffic,
// checked against a per-cycle scoreboard of expected register file writes.
module tb_wb_arbiter;
    localparam int XLEN = 64;
    localparam int RA_W = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    wb_arbiter_if #(.XLEN(XLEN), .RA_W(RA_W)) bus ();

    wb_arbiter #(.XLEN(XLEN), .RA_W(RA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic            en;
        logic [RA_W-1:0] addr;
        logic [XLEN-1:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] m_busy    = '0;
    logic        m_last_ls = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model, evaluated mid-cycle while inputs are stable.
    always @(negedge clk) begin
        wr_t  cur;
        wr_t  nxt;
        logic m_ex_rdy;
        logic m_ls_rdy;
        logic m_iss_rdy;
        if (rst) begin
            exp_q.delete();
            m_busy    = '0;
            m_last_ls = 1'b0;
        end
        if (bus.ex_valid && bus.ls_valid) begin
            m_ls_rdy = !m_last_ls;
            m_ex_rdy = m_last_ls;
        end else begin
            m_ex_rdy = bus.ex_valid;
            m_ls_rdy = bus.ls_valid;
        end
        m_iss_rdy = !(bus.iss_wen && bus.iss_rd != 0 && m_busy[bus.iss_rd]);
        check("ex_ready", bus.ex_ready, m_ex_rdy);
        check("ls_ready", bus.ls_ready, m_ls_rdy);
        check("iss_ready", bus.iss_ready, m_iss_rdy);
        check("rs1_busy", bus.rs1_busy, (bus.rs1_addr != 0) && m_busy[bus.rs1_addr]);
        check("rs2_busy", bus.rs2_busy, (bus.rs2_addr != 0) && m_busy[bus.rs2_addr]);
        if (rst) begin
            check("rst_wr_en", bus.wr_en_o, 0);
            check("rst_wr_addr", bus.wr_addr_o, 0);
            check("rst_wr_data", bus.wr_data_o, 0);
            exp_q.push_back('0);
        end else begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 0, 1);
                cur = '0;
            end else begin
                cur = exp_q.pop_front();
            end
            check("wr_en_o", bus.wr_en_o, cur.en);
            if (cur.en) begin
                check("wr_addr_o", bus.wr_addr_o, cur.addr);
                check("wr_data_o", bus.wr_data_o, cur.data);
            end
            nxt = '0;
            if (m_ls_rdy) begin
                nxt.en   = bus.ls_wen && bus.ls_rd != 0;
                nxt.addr = bus.ls_rd;
                nxt.data = bus.ls_data;
            end else if (m_ex_rdy) begin
                nxt.en   = bus.ex_wen && bus.ex_rd != 0;
                nxt.addr = bus.ex_rd;
                nxt.data = bus.ex_data;
            end
            exp_q.push_back(nxt);
            if (bus.ex_valid && bus.ls_valid) m_last_ls = m_ls_rdy;
            if (cur.en) m_busy[cur.addr] = 1'b0;
            if (bus.iss_valid && m_iss_rdy && bus.iss_wen && bus.iss_rd != 0)
                m_busy[bus.iss_rd] = 1'b1;
            if (bus.flush) m_busy = '0;
        end
    end

    initial begin
        int   exp_rr[4] = '{2, 1, 2, 1};
        logic ex_hold;
        logic ls_hold;

        bus.ex_valid = 1'b0; bus.ex_wen = 1'b0; bus.ex_rd = '0; bus.ex_data = '0;
        bus.ls_valid = 1'b0; bus.ls_wen = 1'b0; bus.ls_rd = '0; bus.ls_data = '0;
        bus.iss_valid = 1'b0; bus.iss_wen = 1'b0; bus.iss_rd = '0;
        bus.rs1_addr = '0; bus.rs2_addr = '0; bus.flush = 1'b0;

        // Reset held with a pending EXU request
        rst = 1'b1;
        bus.ex_valid = 1'b1; bus.ex_wen = 1'b1; bus.ex_rd = 5; bus.ex_data = 64'h1234;
        repeat (2) @(negedge clk);
        check("rst_hold_wr_en", bus.wr_en_o, 0);
        check("rst_hold_iss_ready", bus.iss_ready, 1);
        check("rst_hold_ex_ready", bus.ex_ready, 1);
        tick(); rst = 1'b0;
        tick(); bus.ex_valid = 1'b0;
        @(negedge clk);
        check("first_wr_en", bus.wr_en_o, 1);
        check("first_wr_addr", bus.wr_addr_o, 5);
        check("first_wr_data", bus.wr_data_o, 64'h1234);

        // Scoreboard lifecycle for x7
        tick(); bus.iss_valid = 1'b1; bus.iss_wen = 1'b1; bus.iss_rd = 7; bus.rs1_addr = 7;
        tick(); bus.iss_valid = 1'b0; bus.iss_wen = 1'b0;
        @(negedge clk);
        check("sb_set_rs1_busy", bus.rs1_busy, 1);
        tick();
        tick(); bus.ls_valid = 1'b1; bus.ls_wen = 1'b1; bus.ls_rd = 7; bus.ls_data = 64'hDEAD;
        tick(); bus.ls_valid = 1'b0;
        @(negedge clk);
        check("sb_commit_wr_en", bus.wr_en_o, 1);
        check("sb_commit_rs1_busy", bus.rs1_busy, 1);
        tick();
        @(negedge clk);
        check("sb_cleared_rs1_busy", bus.rs1_busy, 0);

        // Round-robin under continuous conflict
        tick();
        bus.ex_valid = 1'b1; bus.ex_wen = 1'b1; bus.ex_rd = 1; bus.ex_data = 64'h11;
        bus.ls_valid = 1'b1; bus.ls_wen = 1'b1; bus.ls_rd = 2; bus.ls_data = 64'h22;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 3) begin
                bus.ex_valid = 1'b0;
                bus.ls_valid = 1'b0;
            end
            @(negedge clk);
            check("rr_wr_en", bus.wr_en_o, 1);
            check("rr_wr_addr", bus.wr_addr_o, exp_rr[i]);
        end

        // x0 and wen=0 produce no write and no pending entry
        tick(); bus.iss_valid = 1'b1; bus.iss_wen = 1'b1; bus.iss_rd = 0;
        @(negedge clk);
        check("x0_iss_ready", bus.iss_ready, 1);
        tick(); bus.iss_valid = 1'b0; bus.iss_wen = 1'b0;
        bus.ex_valid = 1'b1; bus.ex_wen = 1'b1; bus.ex_rd = 0; bus.ex_data = 64'hFF;
        tick(); bus.ex_valid = 1'b0;
        @(negedge clk);
        check("x0_wr_en", bus.wr_en_o, 0);
        tick(); bus.iss_valid = 1'b1; bus.iss_wen = 1'b1; bus.iss_rd = 3; bus.rs2_addr = 3;
        tick(); bus.iss_valid = 1'b0; bus.iss_wen = 1'b0;
        bus.ls_valid = 1'b1; bus.ls_wen = 1'b0; bus.ls_rd = 3; bus.ls_data = 64'h33;
        tick(); bus.ls_valid = 1'b0;
        @(negedge clk);
        check("wen0_wr_en", bus.wr_en_o, 0);
        check("wen0_busy3", bus.rs2_busy, 1);
        tick();
        @(negedge clk);
        check("wen0_busy3_held", bus.rs2_busy, 1);

        // WAW block, flush, flush racing an issue and a write
        tick(); bus.iss_valid = 1'b1; bus.iss_wen = 1'b1; bus.iss_rd = 9; bus.rs1_addr = 9;
        tick(); bus.iss_valid = 1'b0;
        @(negedge clk);
        check("waw_iss_ready", bus.iss_ready, 0);
        tick(); bus.flush = 1'b1;
        tick(); bus.flush = 1'b0;
        @(negedge clk);
        check("flush_busy9", bus.rs1_busy, 0);
        check("flush_iss_ready", bus.iss_ready, 1);
        tick(); bus.flush = 1'b1; bus.iss_valid = 1'b1; bus.iss_rd = 4; bus.rs1_addr = 4;
        bus.ex_valid = 1'b1; bus.ex_wen = 1'b1; bus.ex_rd = 6; bus.ex_data = 64'h66;
        tick(); bus.flush = 1'b0; bus.iss_valid = 1'b0; bus.iss_wen = 1'b0; bus.ex_valid = 1'b0;
        @(negedge clk);
        check("flush_set_busy4", bus.rs1_busy, 0);
        check("flush_keeps_write", bus.wr_en_o, 1);
        check("flush_keeps_addr", bus.wr_addr_o, 6);

        // Asynchronous reset while a write is on the port
        tick(); bus.ex_valid = 1'b1; bus.ex_wen = 1'b1; bus.ex_rd = 10; bus.ex_data = 64'hABC;
        tick(); bus.ex_valid = 1'b0;
        check("pre_rst_wr_en", bus.wr_en_o, 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_wr_en", bus.wr_en_o, 0);
        check("async_rst_wr_data", bus.wr_data_o, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("no_write_after_rst", bus.wr_en_o, 0);

        // Random traffic; a source keeps its payload while stalled
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            ex_hold = bus.ex_valid && !bus.ex_ready;
            ls_hold = bus.ls_valid && !bus.ls_ready;
            tick();
            if (!ex_hold) begin
                bus.ex_valid = ($urandom_range(0, 2) != 0);
                bus.ex_wen   = ($urandom_range(0, 3) != 0);
                bus.ex_rd    = RA_W'($urandom_range(0, 7));
                bus.ex_data  = {$urandom, $urandom};
            end
            if (!ls_hold) begin
                bus.ls_valid = ($urandom_range(0, 2) != 0);
                bus.ls_wen   = ($urandom_range(0, 3) != 0);
                bus.ls_rd    = RA_W'($urandom_range(0, 7));
                bus.ls_data  = {$urandom, $urandom};
            end
            bus.iss_valid = ($urandom_range(0, 1) != 0);
            bus.iss_wen   = ($urandom_range(0, 3) != 0);
            bus.iss_rd    = RA_W'($urandom_range(0, 7));
            bus.rs1_addr  = RA_W'($urandom_range(0, 7));
            bus.rs2_addr  = RA_W'($urandom_range(0, 7));
            bus.flush     = ($urandom_range(0, 19) == 0);
        end
        tick();
        bus.ex_valid = 1'b0; bus.ls_valid = 1'b0; bus.iss_valid = 1'b0; bus.flush = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
